// File: rtl/quadratic_issuer.sv
// Host-side initiator for the quadratic root solver: splits {a,b,c} triples onto the
// solver's three coefficient streams and returns its roots in order through a result FIFO.
module quadratic_issuer #(
  parameter int SIZE         = 64,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [3*SIZE-1:0]             s_axis_coef_tdata,
  input  logic                          s_axis_coef_tvalid,
  output logic                          s_axis_coef_tready,
  output logic [SIZE-1:0]               m_axis_a_tdata,
  output logic                          m_axis_a_tvalid,
  input  logic                          m_axis_a_tready,
  output logic [SIZE-1:0]               m_axis_b_tdata,
  output logic                          m_axis_b_tvalid,
  input  logic                          m_axis_b_tready,
  output logic [SIZE-1:0]               m_axis_c_tdata,
  output logic                          m_axis_c_tvalid,
  input  logic                          m_axis_c_tready,
  input  logic [SIZE-1:0]               s_axis_root_tdata,
  input  logic                          s_axis_root_tvalid,
  output logic                          s_axis_root_tready,
  output logic [SIZE-1:0]               m_axis_out_tdata,
  output logic                          m_axis_out_tvalid,
  input  logic                          m_axis_out_tready,
  output logic [$clog2(MAX_INFLIGHT):0] outstanding,
  output logic                          err_overflow,
  output logic                          err_spurious
);

  localparam int CW = $clog2(MAX_INFLIGHT) + 1;
  localparam int AW = $clog2(MAX_INFLIGHT);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

  // Saturating up/down step: simultaneous inc and dec cancel out.
  function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] v,
                                             input logic inc, input logic dec);
    logic [CW-1:0] r;
    r = v;
    if (inc && !dec && v != CNT_MAX)
      r = v + CW'(1);
    else if (dec && !inc && v != '0)
      r = v - CW'(1);
    return r;
  endfunction

  logic [SIZE-1:0] a_p1, b_p1, c_p1;
  logic            vld_p1;
  logic            sent_a, sent_b, sent_c;
  logic            hs_a, hs_b, hs_c, done;
  logic            coef_hs, root_hs, out_hs;
  logic [CW-1:0]   issued;
  logic [CW-1:0]   fifo_cnt;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [SIZE-1:0] mem [MAX_INFLIGHT];
  logic            fifo_full, wr_en, rd_en;

  assign m_axis_a_tdata  = a_p1;
  assign m_axis_b_tdata  = b_p1;
  assign m_axis_c_tdata  = c_p1;
  assign m_axis_a_tvalid = vld_p1 & ~sent_a;
  assign m_axis_b_tvalid = vld_p1 & ~sent_b;
  assign m_axis_c_tvalid = vld_p1 & ~sent_c;

  assign hs_a = m_axis_a_tvalid & m_axis_a_tready;
  assign hs_b = m_axis_b_tvalid & m_axis_b_tready;
  assign hs_c = m_axis_c_tvalid & m_axis_c_tready;
  assign done = vld_p1 & (sent_a | hs_a) & (sent_b | hs_b) & (sent_c | hs_c);

  assign s_axis_coef_tready = (~vld_p1 | done) & (outstanding < CNT_MAX) & ~areset;
  assign coef_hs            = s_axis_coef_tvalid & s_axis_coef_tready;

  assign s_axis_root_tready = ~areset;
  assign root_hs            = s_axis_root_tvalid & s_axis_root_tready;

  // FIFO head comes straight from registered storage, so roots reach the output a cycle later.
  assign m_axis_out_tvalid = (fifo_cnt != '0);
  assign m_axis_out_tdata  = mem[rd_ptr];
  assign out_hs            = m_axis_out_tvalid & m_axis_out_tready;

  assign fifo_full = (fifo_cnt == CNT_MAX);
  assign rd_en     = out_hs;
  assign wr_en     = root_hs & (~fifo_full | rd_en);

  // Stage p1: holding register control and bookkeeping counters
  always_ff @(posedge aclk) begin
    if (areset) begin
      vld_p1       <= 1'b0;
      sent_a       <= 1'b0;
      sent_b       <= 1'b0;
      sent_c       <= 1'b0;
      outstanding  <= '0;
      issued       <= '0;
      fifo_cnt     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      err_overflow <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      if (coef_hs) begin
        vld_p1 <= 1'b1;
        sent_a <= 1'b0;
        sent_b <= 1'b0;
        sent_c <= 1'b0;
      end else begin
        if (done)
          vld_p1 <= 1'b0;
        sent_a <= sent_a | hs_a;
        sent_b <= sent_b | hs_b;
        sent_c <= sent_c | hs_c;
      end
      outstanding <= cnt_step(outstanding, coef_hs, out_hs);
      issued      <= cnt_step(issued, done, root_hs);
      fifo_cnt    <= cnt_step(fifo_cnt, wr_en, rd_en);
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (rd_en)
        rd_ptr <= rd_ptr + AW'(1);
      err_overflow <= err_overflow | (root_hs & fifo_full & ~rd_en);
      err_spurious <= err_spurious | (root_hs & (issued == '0));
    end
  end

  always_ff @(posedge aclk) begin
    if (coef_hs) begin
      a_p1 <= s_axis_coef_tdata[3*SIZE-1:2*SIZE];
      b_p1 <= s_axis_coef_tdata[2*SIZE-1:SIZE];
      c_p1 <= s_axis_coef_tdata[SIZE-1:0];
    end
    if (wr_en)
      mem[wr_ptr] <= s_axis_root_tdata;
  end

endmodule

// File: tb/tb_quadratic_issuer.sv
// Directed bench for quadratic_issuer; the bench plays the solver and the consumer,
// and a queue scoreboard checks every root delivered on m_axis_out in order.
module tb_quadratic_issuer;
  localparam int SIZE = 64;
  localparam int MAX_INFLIGHT = 16;
  localparam logic [63:0] F_ONE = 64'h3FF0000000000000;
  localparam logic [63:0] F_M3  = 64'hC008000000000000;
  localparam logic [63:0] F_TWO = 64'h4000000000000000;

  logic              aclk = 1'b0;
  logic              areset;
  logic [3*SIZE-1:0] s_axis_coef_tdata;
  logic              s_axis_coef_tvalid;
  logic              s_axis_coef_tready;
  logic [SIZE-1:0]   m_axis_a_tdata, m_axis_b_tdata, m_axis_c_tdata;
  logic              m_axis_a_tvalid, m_axis_b_tvalid, m_axis_c_tvalid;
  logic              m_axis_a_tready, m_axis_b_tready, m_axis_c_tready;
  logic [SIZE-1:0]   s_axis_root_tdata;
  logic              s_axis_root_tvalid;
  logic              s_axis_root_tready;
  logic [SIZE-1:0]   m_axis_out_tdata;
  logic              m_axis_out_tvalid;
  logic              m_axis_out_tready;
  logic [$clog2(MAX_INFLIGHT):0] outstanding;
  logic              err_overflow, err_spurious;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  quadratic_issuer #(.SIZE(SIZE), .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_coef_tdata(s_axis_coef_tdata), .s_axis_coef_tvalid(s_axis_coef_tvalid),
    .s_axis_coef_tready(s_axis_coef_tready),
    .m_axis_a_tdata(m_axis_a_tdata), .m_axis_a_tvalid(m_axis_a_tvalid), .m_axis_a_tready(m_axis_a_tready),
    .m_axis_b_tdata(m_axis_b_tdata), .m_axis_b_tvalid(m_axis_b_tvalid), .m_axis_b_tready(m_axis_b_tready),
    .m_axis_c_tdata(m_axis_c_tdata), .m_axis_c_tvalid(m_axis_c_tvalid), .m_axis_c_tready(m_axis_c_tready),
    .s_axis_root_tdata(s_axis_root_tdata), .s_axis_root_tvalid(s_axis_root_tvalid),
    .s_axis_root_tready(s_axis_root_tready),
    .m_axis_out_tdata(m_axis_out_tdata), .m_axis_out_tvalid(m_axis_out_tvalid),
    .m_axis_out_tready(m_axis_out_tready),
    .outstanding(outstanding), .err_overflow(err_overflow), .err_spurious(err_spurious)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic send_root(input logic [63:0] d, input bit push);
    s_axis_root_tdata  = d;
    s_axis_root_tvalid = 1'b1;
    if (push) exp_q.push_back(d);
    tick();
    s_axis_root_tvalid = 1'b0;
  endtask

  // Consumer-side scoreboard: every out handshake must match the oldest expected root.
  always @(negedge aclk) begin
    if (!areset && m_axis_out_tvalid && m_axis_out_tready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL out_unexpected observed=%h expected=none", m_axis_out_tdata);
      end else begin
        chk("out_data", m_axis_out_tdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a_cnt;
    int accepted;
    areset = 1'b1;
    s_axis_coef_tdata = '0;
    s_axis_coef_tvalid = 1'b0;
    m_axis_a_tready = 1'b1;
    m_axis_b_tready = 1'b1;
    m_axis_c_tready = 1'b1;
    s_axis_root_tdata = '0;
    s_axis_root_tvalid = 1'b0;
    m_axis_out_tready = 1'b0;
    tick();
    tick();
    chk("rst_coef_tready", 64'(s_axis_coef_tready), 64'd0);
    chk("rst_root_tready", 64'(s_axis_root_tready), 64'd0);
    chk("rst_a_valid", 64'(m_axis_a_tvalid), 64'd0);
    chk("rst_out_valid", 64'(m_axis_out_tvalid), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err_overflow", 64'(err_overflow), 64'd0);
    chk("rst_err_spurious", 64'(err_spurious), 64'd0);
    areset = 1'b0;
    #1;
    chk("idle_coef_tready", 64'(s_axis_coef_tready), 64'd1);
    chk("idle_root_tready", 64'(s_axis_root_tready), 64'd1);

    // Single triple
    m_axis_out_tready = 1'b1;
    s_axis_coef_tdata = {F_ONE, F_M3, F_TWO};
    s_axis_coef_tvalid = 1'b1;
    tick();
    s_axis_coef_tvalid = 1'b0;
    chk("t1_a_valid", 64'(m_axis_a_tvalid), 64'd1);
    chk("t1_b_valid", 64'(m_axis_b_tvalid), 64'd1);
    chk("t1_c_valid", 64'(m_axis_c_tvalid), 64'd1);
    chk("t1_a_data", m_axis_a_tdata, F_ONE);
    chk("t1_b_data", m_axis_b_tdata, F_M3);
    chk("t1_c_data", m_axis_c_tdata, F_TWO);
    chk("t1_outstanding", 64'(outstanding), 64'd1);
    tick();
    chk("t1_a_valid_drop", 64'(m_axis_a_tvalid), 64'd0);
    chk("t1_b_valid_drop", 64'(m_axis_b_tvalid), 64'd0);
    chk("t1_c_valid_drop", 64'(m_axis_c_tvalid), 64'd0);
    send_root(F_ONE, 1'b1);
    chk("t1_out_valid", 64'(m_axis_out_tvalid), 64'd1);
    chk("t1_out_data", m_axis_out_tdata, F_ONE);
    tick();
    chk("t1_outstanding_done", 64'(outstanding), 64'd0);
    chk("t1_out_valid_drop", 64'(m_axis_out_tvalid), 64'd0);
    chk("t1_err_spurious", 64'(err_spurious), 64'd0);

    // Skewed b ready
    m_axis_b_tready = 1'b0;
    s_axis_coef_tdata = {F_ONE, F_M3, F_TWO};
    s_axis_coef_tvalid = 1'b1;
    tick();
    s_axis_coef_tvalid = 1'b0;
    a_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (m_axis_a_tvalid && m_axis_a_tready) a_cnt++;
      chk("skew_b_valid", 64'(m_axis_b_tvalid), 64'd1);
      chk("skew_b_data", m_axis_b_tdata, F_M3);
      chk("skew_coef_tready", 64'(s_axis_coef_tready), 64'd0);
      tick();
    end
    chk("skew_a_handshakes", 64'(a_cnt), 64'd1);
    chk("skew_c_valid", 64'(m_axis_c_tvalid), 64'd0);
    m_axis_b_tready = 1'b1;
    #1;
    chk("skew_coef_tready_release", 64'(s_axis_coef_tready), 64'd1);
    tick();
    chk("skew_b_valid_drop", 64'(m_axis_b_tvalid), 64'd0);
    send_root(F_TWO, 1'b1);
    tick();
    chk("skew_outstanding", 64'(outstanding), 64'd0);

    // Credit limit: 20 offered with the consumer stalled
    m_axis_out_tready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      s_axis_coef_tdata = {64'(i), 64'(i + 100), 64'(i + 200)};
      s_axis_coef_tvalid = 1'b1;
      #1;
      if (s_axis_coef_tready) accepted++;
      tick();
    end
    s_axis_coef_tvalid = 1'b0;
    chk("credit_accepted", 64'(accepted), 64'd16);
    chk("credit_outstanding", 64'(outstanding), 64'd16);
    chk("credit_coef_tready", 64'(s_axis_coef_tready), 64'd0);
    for (int k = 0; k < 16; k++) send_root(64'(100 + k), 1'b1);
    chk("credit_err_spurious", 64'(err_spurious), 64'd0);

    // One out handshake admits one more triple
    m_axis_out_tready = 1'b1;
    s_axis_coef_tvalid = 1'b1;
    #1;
    chk("admit_blocked", 64'(s_axis_coef_tready), 64'd0);
    tick();
    m_axis_out_tready = 1'b0;
    #1;
    chk("admit_open", 64'(s_axis_coef_tready), 64'd1);
    tick();
    s_axis_coef_tvalid = 1'b0;
    #1;
    chk("admit_closed", 64'(s_axis_coef_tready), 64'd0);
    chk("admit_outstanding", 64'(outstanding), 64'd16);
    tick();
    send_root(64'd116, 1'b1);
    chk("full_err_overflow0", 64'(err_overflow), 64'd0);
    chk("full_err_spurious0", 64'(err_spurious), 64'd0);

    // Free one slot, then a root with nothing issued
    m_axis_out_tready = 1'b1;
    tick();
    m_axis_out_tready = 1'b0;
    chk("pop_outstanding", 64'(outstanding), 64'd15);
    send_root(64'd117, 1'b1);
    chk("spurious_set", 64'(err_spurious), 64'd1);
    chk("spurious_overflow", 64'(err_overflow), 64'd0);

    // Full FIFO: root write, out read and coefficient accept in one cycle
    s_axis_root_tdata = 64'd118;
    s_axis_root_tvalid = 1'b1;
    exp_q.push_back(64'd118);
    m_axis_out_tready = 1'b1;
    s_axis_coef_tdata = {F_TWO, F_ONE, F_M3};
    s_axis_coef_tvalid = 1'b1;
    #1;
    chk("simul_coef_tready", 64'(s_axis_coef_tready), 64'd1);
    tick();
    s_axis_root_tvalid = 1'b0;
    m_axis_out_tready = 1'b0;
    s_axis_coef_tvalid = 1'b0;
    chk("simul_outstanding", 64'(outstanding), 64'd15);
    chk("simul_err_overflow", 64'(err_overflow), 64'd0);
    chk("simul_err_spurious_sticky", 64'(err_spurious), 64'd1);

    // FIFO is still full: this root must be dropped
    send_root(64'hBAD0BAD0BAD0BAD0, 1'b0);
    chk("overflow_set", 64'(err_overflow), 64'd1);
    tick();
    chk("overflow_sticky", 64'(err_overflow), 64'd1);
    chk("spurious_sticky", 64'(err_spurious), 64'd1);

    m_axis_out_tready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    tick();
    chk("drain_out_valid", 64'(m_axis_out_tvalid), 64'd0);
    chk("drain_outstanding", 64'(outstanding), 64'd0);

    // Mid-operation reset with 5 triples outstanding
    m_axis_out_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_axis_coef_tdata = {64'(i + 500), 64'(i + 600), 64'(i + 700)};
      s_axis_coef_tvalid = 1'b1;
      tick();
    end
    s_axis_coef_tvalid = 1'b0;
    m_axis_b_tready = 1'b0;
    send_root(64'd300, 1'b0);
    chk("mid_outstanding", 64'(outstanding), 64'd5);
    chk("mid_out_valid", 64'(m_axis_out_tvalid), 64'd1);
    areset = 1'b1;
    tick();
    chk("mrst_a_valid", 64'(m_axis_a_tvalid), 64'd0);
    chk("mrst_b_valid", 64'(m_axis_b_tvalid), 64'd0);
    chk("mrst_c_valid", 64'(m_axis_c_tvalid), 64'd0);
    chk("mrst_out_valid", 64'(m_axis_out_tvalid), 64'd0);
    chk("mrst_outstanding", 64'(outstanding), 64'd0);
    chk("mrst_err_overflow", 64'(err_overflow), 64'd0);
    chk("mrst_err_spurious", 64'(err_spurious), 64'd0);
    chk("mrst_coef_tready", 64'(s_axis_coef_tready), 64'd0);
    chk("mrst_root_tready", 64'(s_axis_root_tready), 64'd0);
    areset = 1'b0;
    m_axis_b_tready = 1'b1;
    m_axis_out_tready = 1'b1;
    s_axis_coef_tdata = {F_TWO, F_ONE, F_M3};
    s_axis_coef_tvalid = 1'b1;
    tick();
    s_axis_coef_tvalid = 1'b0;
    chk("post_a_data", m_axis_a_tdata, F_TWO);
    chk("post_b_valid", 64'(m_axis_b_tvalid), 64'd1);
    chk("post_outstanding", 64'(outstanding), 64'd1);
    tick();
    send_root(F_TWO, 1'b1);
    chk("post_out_data", m_axis_out_tdata, F_TWO);
    tick();
    chk("post_outstanding_done", 64'(outstanding), 64'd0);
    chk("post_err_spurious", 64'(err_spurious), 64'd0);
    chk("post_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/quadratic_issuer.md
# quadratic_issuer

Host-side initiator for the `quadratic` root solver. It accepts packed {a,b,c} coefficient triples and splits each one onto the solver's three independent AXI-Stream coefficient inputs. It collects the solver's roots into an internal result FIFO and returns them, in order, on a single output stream. A credit counter bounds the number of in-flight triples. This lets the solver's result `tready` be tied high, because the solver's internal delay lines ignore back-pressure.

## Interface
Parameters:
- `SIZE`, 64: float width in bits.
- `MAX_INFLIGHT`, 16: credit limit and result-FIFO depth; must be a power of 2, minimum 2.

Ports (`CW = $clog2(MAX_INFLIGHT)+1`):
- `aclk` in 1: single clock.
- `areset` in 1: reset, synchronous, active-high.
- `s_axis_coef_tdata` in 3*SIZE: {a[3S-1:2S], b[2S-1:S], c[S-1:0]}.
- `s_axis_coef_tvalid` in 1, `s_axis_coef_tready` out 1.
- `m_axis_a_tdata` out SIZE, `m_axis_a_tvalid` out 1, `m_axis_a_tready` in 1: to solver input a.
- `m_axis_b_tdata` / `m_axis_b_tvalid` / `m_axis_b_tready`: same, for b.
- `m_axis_c_tdata` / `m_axis_c_tvalid` / `m_axis_c_tready`: same, for c.
- `s_axis_root_tdata` in SIZE, `s_axis_root_tvalid` in 1, `s_axis_root_tready` out 1: from solver result.
- `m_axis_out_tdata` out SIZE, `m_axis_out_tvalid` out 1, `m_axis_out_tready` in 1: roots to the consumer.
- `outstanding` out CW: triples accepted but not yet delivered on `m_axis_out`.
- `err_overflow` out 1: sticky; a root arrived while the FIFO was full.
- `err_spurious` out 1: sticky; a root arrived while no issued triple was awaiting a result.

## Operation
- **Holding register.** One holding register stores the triple plus per-channel `sent_a`, `sent_b`, `sent_c` flags.
  - `m_axis_x_tvalid = hold_valid & ~sent_x`.
  - A channel's flag sets on its handshake.
  - The register is done when each channel is either already sent or handshaking this cycle.
- **Coefficient accept.** `s_axis_coef_tready = (~hold_valid | done) & (outstanding < MAX_INFLIGHT) & ~areset`.
  - On accept: load the triple, clear all sent flags, set `hold_valid`.
  - When done with no new accept, clear `hold_valid`.
- **Outstanding counter.**
  - +1 on a coefficient handshake, -1 on an `m_axis_out` handshake; both in the same cycle leaves it unchanged.
  - It never exceeds `MAX_INFLIGHT` and never goes below 0.
- **Issued counter.** A separate counter tracks triples fully sent to the solver but without a returned root.
  - +1 when the holding register completes, -1 on a root handshake.
- **Result FIFO.** Depth `MAX_INFLIGHT`, with a circular pointer wrap.
  - `s_axis_root_tready = ~areset` (always accepting).
  - If a root arrives with the FIFO full: drop it and set `err_overflow`.
  - If a root arrives with the issued counter at 0: still write it and set `err_spurious`.
  - A simultaneous write and read on a full FIFO is legal and keeps the FIFO full.
- **Ordering.** Output order equals input order. The solver is in-order and this block never reorders.
- **Reset, all cases including mid-operation.** Occurs at the next `aclk` edge with `areset` high.
  - All tvalids 0; `hold_valid` 0; FIFO empty; `outstanding` 0; issued counter 0; error flags 0.
  - `s_axis_coef_tready` and `s_axis_root_tready` are 0 while `areset` is high.
  - The solver must receive `aresetn = ~areset` so that no stale roots return.

## Timing
- Coefficient handshake at edge N: `m_axis_a/b/c_tvalid` high from cycle N+1 (registered).
- Sustained throughput is 1 triple/cycle when all three solver readys are high.
- A channel stalled by its ready holds its data and valid stable; completed channels drop valid the cycle after their handshake.
- A new triple can be accepted in the same cycle the last pending channel handshakes.
- Root handshake at edge M: `m_axis_out_tvalid` high from cycle M+1 with that data.
  - The FIFO head is registered; there is no combinational root-to-out path.
- `m_axis_out` holds data and valid stable while `tready` is low.
- End-to-end latency = solver latency (91) + 2 cycles.

## Test plan
- **Single triple.** Send a=1.0, b=-3.0, c=2.0 with all readys high. Required: a/b/c valid for exactly 1 cycle at N+1, `outstanding`=1. After a returned root 1.0, `m_axis_out` shows 0x3FF0000000000000 one cycle later and `outstanding` returns to 0.
- **Skewed channel ready.** Hold `m_axis_b_tready` low for 5 cycles while a and c are ready. Required: a and c each handshake once, b stays valid with data stable until its ready rises, and `s_axis_coef_tready` stays 0 until the b handshake.
- **Credit limit.** Send 20 triples with `m_axis_out_tready`=0 and MAX_INFLIGHT=16. Required: exactly 16 accepted, `outstanding`=16, `s_axis_coef_tready`=0. Each subsequent out handshake admits one more triple.
- **Full FIFO with simultaneous events.** With the FIFO full, root write and out read in the same cycle → no `err_overflow`, FIFO count unchanged, `outstanding` unchanged.
- **Error flags.** Root valid with the issued counter at 0 → `err_spurious`=1 and stays 1. Forcing a 17th root into a full FIFO → `err_overflow`=1 and the data is dropped.
- **Mid-operation reset.** Pulse `areset` with 5 triples outstanding. Required: next cycle all valids 0, `outstanding`=0, flags 0; normal operation on the following triple.
